multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control FSM (Moore) with a bounded memory-wait counter,
// sticky illegal-opcode / memory-timeout flags and a debug view of the state.
module multicycle_controller #(
    parameter int EXT_OPS     = 0,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_write,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        branch_ne,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic        illegal,
    output logic        timeout,
    output logic [3:0]  state_o
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,  S_IEXEC  = 4'd9,  S_IWB    = 4'd10, S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic       EXT      = (EXT_OPS != 0);
    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic        illegal_q, illegal_d;
    logic        timeout_q, timeout_d;
    logic        mem_wait;
    logic        dec_illegal;
    logic [5:0]  opcode;
    logic        unused_instr;

    assign opcode       = instr[31:26];
    assign unused_instr = ^instr[25:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            wait_q    <= 8'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = 8'd0;
        illegal_d   = illegal_q;
        timeout_d   = timeout_q;
        mem_wait    = 1'b0;
        dec_illegal = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE; else mem_wait = 1'b1;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:              state_d = S_EXEC;
                    OP_LW, OP_SW:          state_d = S_MEMADR;
                    OP_BEQ:                state_d = S_BRANCH;
                    OP_ADDI:               state_d = S_IEXEC;
                    OP_J:                  state_d = S_JUMP;
                    OP_BNE:                if (EXT) state_d = S_BRANCH; else dec_illegal = 1'b1;
                    OP_ANDI, OP_ORI, OP_SLTI:
                                           if (EXT) state_d = S_IEXEC; else dec_illegal = 1'b1;
                    default:               dec_illegal = 1'b1;
                endcase
                if (dec_illegal) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB; else mem_wait = 1'b1;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH; else mem_wait = 1'b1;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
        // A completing access takes priority over the timeout on the limit cycle.
        if (mem_wait) begin
            if (wait_q == WAIT_LIMIT) begin
                state_d   = S_TRAP;
                timeout_d = 1'b1;
            end else begin
                wait_d = wait_q + 8'd1;
            end
        end
    end

    always_comb begin
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_src        = 2'b00;
        // Strobes are gated by rst_n so that reset silences them without a clock edge.
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    alu_src_b = 2'b01;
                end
                S_DECODE: alu_src_b = 2'b11;
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_src        = 2'b01;
                    pc_write_cond = 1'b1;
                    branch_ne     = (opcode == OP_BNE);
                end
                S_IEXEC, S_IWB: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = (opcode == OP_ADDI) ? 2'b00 : 2'b11;
                    reg_write = (state_q == S_IWB);
                end
                S_JUMP: begin
                    pc_src   = 2'b10;
                    pc_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign illegal = illegal_q;
    assign timeout = timeout_q;
    assign state_o = state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: one instance with the extended opcodes
// and a 4-cycle memory limit, and one default instance for illegal-opcode handling.
module tb_multicycle_controller;
    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        mem_ready;

    logic x_mem_req, x_mem_write, x_iord, x_ir_write, x_pc_write, x_pc_write_cond;
    logic x_branch_ne, x_reg_write, x_reg_dst, x_mem_to_reg, x_alu_src_a;
    logic [1:0] x_alu_src_b, x_alu_op, x_pc_src;
    logic x_illegal, x_timeout;
    logic [3:0] x_state_o;

    logic z_mem_req, z_mem_write, z_iord, z_ir_write, z_pc_write, z_pc_write_cond;
    logic z_branch_ne, z_reg_write, z_reg_dst, z_mem_to_reg, z_alu_src_a;
    logic [1:0] z_alu_src_b, z_alu_op, z_pc_src;
    logic z_illegal, z_timeout;
    logic [3:0] z_state_o;

    logic [16:0] x_ctrl, z_ctrl;
    int checks = 0;
    int errors = 0;

    // Control bundle layout: mem_req mem_write iord ir_write pc_write pc_write_cond
    // branch_ne reg_write reg_dst mem_to_reg alu_src_a | alu_src_b | alu_op | pc_src
    localparam logic [16:0] C_FETCH_R = 17'b1_0_0_1_1_0_0_0_0_0_0_01_00_00;
    localparam logic [16:0] C_FETCH_N = 17'b1_0_0_0_0_0_0_0_0_0_0_01_00_00;
    localparam logic [16:0] C_DECODE  = 17'b0_0_0_0_0_0_0_0_0_0_0_11_00_00;
    localparam logic [16:0] C_MEMADR  = 17'b0_0_0_0_0_0_0_0_0_0_1_10_00_00;
    localparam logic [16:0] C_MEMRD   = 17'b1_0_1_0_0_0_0_0_0_0_0_00_00_00;
    localparam logic [16:0] C_MEMWB   = 17'b0_0_0_0_0_0_0_1_0_1_0_00_00_00;
    localparam logic [16:0] C_MEMWR   = 17'b1_1_1_0_0_0_0_0_0_0_0_00_00_00;
    localparam logic [16:0] C_EXEC    = 17'b0_0_0_0_0_0_0_0_0_0_1_00_10_00;
    localparam logic [16:0] C_ALUWB   = 17'b0_0_0_0_0_0_0_1_1_0_0_00_00_00;
    localparam logic [16:0] C_BNE     = 17'b0_0_0_0_0_1_1_0_0_0_1_00_01_01;
    localparam logic [16:0] C_IEX_ORI = 17'b0_0_0_0_0_0_0_0_0_0_1_10_11_00;
    localparam logic [16:0] C_IWB_ORI = 17'b0_0_0_0_0_0_0_1_0_0_1_10_11_00;
    localparam logic [16:0] C_JUMP    = 17'b0_0_0_0_1_0_0_0_0_0_0_00_00_10;
    localparam logic [16:0] C_ZERO    = 17'b0;

    localparam logic [31:0] I_LW  = {6'b100011, 26'h0A5_0004};
    localparam logic [31:0] I_SW  = {6'b101011, 26'h0A5_0008};
    localparam logic [31:0] I_R   = {6'b000000, 26'h04B_5020};
    localparam logic [31:0] I_BNE = {6'b000101, 26'h022_FFFC};
    localparam logic [31:0] I_ORI = {6'b001101, 26'h021_00FF};
    localparam logic [31:0] I_J   = {6'b000010, 26'h000_0040};

    assign x_ctrl = {x_mem_req, x_mem_write, x_iord, x_ir_write, x_pc_write, x_pc_write_cond,
                     x_branch_ne, x_reg_write, x_reg_dst, x_mem_to_reg, x_alu_src_a,
                     x_alu_src_b, x_alu_op, x_pc_src};
    assign z_ctrl = {z_mem_req, z_mem_write, z_iord, z_ir_write, z_pc_write, z_pc_write_cond,
                     z_branch_ne, z_reg_write, z_reg_dst, z_mem_to_reg, z_alu_src_a,
                     z_alu_src_b, z_alu_op, z_pc_src};

    multicycle_controller #(.EXT_OPS(1), .MEM_TIMEOUT(4)) dut_x (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
        .mem_req(x_mem_req), .mem_write(x_mem_write), .iord(x_iord), .ir_write(x_ir_write),
        .pc_write(x_pc_write), .pc_write_cond(x_pc_write_cond), .branch_ne(x_branch_ne),
        .reg_write(x_reg_write), .reg_dst(x_reg_dst), .mem_to_reg(x_mem_to_reg),
        .alu_src_a(x_alu_src_a), .alu_src_b(x_alu_src_b), .alu_op(x_alu_op), .pc_src(x_pc_src),
        .illegal(x_illegal), .timeout(x_timeout), .state_o(x_state_o)
    );

    multicycle_controller dut_z (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
        .mem_req(z_mem_req), .mem_write(z_mem_write), .iord(z_iord), .ir_write(z_ir_write),
        .pc_write(z_pc_write), .pc_write_cond(z_pc_write_cond), .branch_ne(z_branch_ne),
        .reg_write(z_reg_write), .reg_dst(z_reg_dst), .mem_to_reg(z_mem_to_reg),
        .alu_src_a(z_alu_src_a), .alu_src_b(z_alu_src_b), .alu_op(z_alu_op), .pc_src(z_pc_src),
        .illegal(z_illegal), .timeout(z_timeout), .state_o(z_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_x(input string tag, input logic [3:0] st, input logic [16:0] ctrl);
        chk({tag, "_state"}, {28'd0, x_state_o}, {28'd0, st});
        chk({tag, "_ctrl"}, {15'd0, x_ctrl}, {15'd0, ctrl});
    endtask

    task automatic step(input logic ready);
        @(posedge clk);
        #1;
        mem_ready = ready;
        #1;
    endtask

    task automatic do_reset(input logic ready);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_x("rst", 4'd0, C_ZERO);
        chk("rst_flags", {30'd0, x_illegal, x_timeout}, 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        mem_ready = ready;
        #1;
        chk_x("rel", 4'd0, ready ? C_FETCH_R : C_FETCH_N);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        instr     = 32'd0;

        // LW, memory always ready: 0,1,2,3,4,0
        instr = I_LW;
        do_reset(1'b1);
        step(1'b1); chk_x("lw_dec", 4'd1, C_DECODE);
        step(1'b1); chk_x("lw_adr", 4'd2, C_MEMADR);
        step(1'b1); chk_x("lw_rd", 4'd3, C_MEMRD);
        step(1'b1); chk_x("lw_wb", 4'd4, C_MEMWB);
        step(1'b1); chk_x("lw_fetch", 4'd0, C_FETCH_R);

        // SW, three wait cycles in MEMWR; ready on the limit cycle must win
        instr = I_SW;
        do_reset(1'b1);
        step(1'b1); chk_x("sw_dec", 4'd1, C_DECODE);
        step(1'b1); chk_x("sw_adr", 4'd2, C_MEMADR);
        step(1'b0); chk_x("sw_wr1", 4'd5, C_MEMWR);
        step(1'b0); chk_x("sw_wr2", 4'd5, C_MEMWR);
        step(1'b0); chk_x("sw_wr3", 4'd5, C_MEMWR);
        step(1'b1); chk_x("sw_wr4", 4'd5, C_MEMWR);
        step(1'b1); chk_x("sw_fetch", 4'd0, C_FETCH_R);
        chk("sw_timeout", {31'd0, x_timeout}, 32'd0);

        // BNE: legal with extended ops, illegal on the default instance
        instr = I_BNE;
        do_reset(1'b1);
        step(1'b1);
        chk_x("bne_dec", 4'd1, C_DECODE);
        chk("z_bne_dec", {28'd0, z_state_o}, 32'd1);
        step(1'b1);
        chk_x("bne_br", 4'd8, C_BNE);
        chk("z_trap_state", {28'd0, z_state_o}, 32'd12);
        chk("z_trap_illegal", {31'd0, z_illegal}, 32'd1);
        chk("z_trap_ctrl", {15'd0, z_ctrl}, 32'd0);
        step(1'b1);
        chk_x("bne_fetch", 4'd0, C_FETCH_R);
        for (int i = 0; i < 19; i++) begin
            step(1'b1);
            chk("z_hold_state", {28'd0, z_state_o}, 32'd12);
            chk("z_hold_illegal", {31'd0, z_illegal}, 32'd1);
            chk("z_hold_ctrl", {15'd0, z_ctrl}, 32'd0);
        end

        // ORI with extended ops
        instr = I_ORI;
        do_reset(1'b1);
        step(1'b1); chk_x("ori_dec", 4'd1, C_DECODE);
        step(1'b1); chk_x("ori_iexec", 4'd9, C_IEX_ORI);
        step(1'b1); chk_x("ori_iwb", 4'd10, C_IWB_ORI);
        step(1'b1); chk_x("ori_fetch", 4'd0, C_FETCH_R);

        // Jump
        instr = I_J;
        do_reset(1'b1);
        step(1'b1); chk_x("j_dec", 4'd1, C_DECODE);
        step(1'b1); chk_x("j_jump", 4'd11, C_JUMP);
        step(1'b1); chk_x("j_fetch", 4'd0, C_FETCH_R);

        // Fetch timeout after exactly four stalled cycles, then reset out of TRAP
        instr = I_LW;
        do_reset(1'b0);
        step(1'b0); chk_x("to_f2", 4'd0, C_FETCH_N);
        step(1'b0); chk_x("to_f3", 4'd0, C_FETCH_N);
        step(1'b0); chk_x("to_f4", 4'd0, C_FETCH_N);
        step(1'b0); chk_x("to_trap", 4'd12, C_ZERO);
        chk("to_flag", {31'd0, x_timeout}, 32'd1);
        step(1'b1); chk_x("to_hold", 4'd12, C_ZERO);
        #2;
        rst_n = 1'b0;
        #1;
        chk("to_rst_flag", {31'd0, x_timeout}, 32'd0);
        chk_x("to_rst", 4'd0, C_ZERO);

        // Ready arrives on the fourth fetch cycle: no timeout
        do_reset(1'b0);
        step(1'b0); chk_x("nt_f2", 4'd0, C_FETCH_N);
        step(1'b0); chk_x("nt_f3", 4'd0, C_FETCH_N);
        step(1'b1); chk_x("nt_f4", 4'd0, C_FETCH_R);
        step(1'b1); chk_x("nt_dec", 4'd1, C_DECODE);
        chk("nt_flag", {31'd0, x_timeout}, 32'd0);

        // R-type, with reset pulsed in ALUWB
        instr = I_R;
        do_reset(1'b1);
        step(1'b1); chk_x("r_dec", 4'd1, C_DECODE);
        step(1'b1); chk_x("r_exec", 4'd6, C_EXEC);
        step(1'b1); chk_x("r_aluwb", 4'd7, C_ALUWB);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_rst_regwrite", {31'd0, x_reg_write}, 32'd0);
        chk_x("r_rst", 4'd0, C_ZERO);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk_x("r_rel", 4'd0, C_FETCH_R);
        chk("r_rel_flags", {30'd0, x_illegal, x_timeout}, 32'd0);
        step(1'b1); chk_x("r_dec2", 4'd1, C_DECODE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
